// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-stage operand select; 1 cycle ID->EX, stall/flush insert bubbles.
// ID_EX_FORWARD_EN: MEM/WB forwarding + load-use stall; undefined: no forwarding, stall on EX/MEM RAW hazards.
// Backpressure: combinational stall tells upstream to hold PC and IF/ID; the ID inputs are re-presented next cycle.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int REGW  = 5,
    parameter int CTRLW = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REGW-1:0]  id_rs,
    input  logic [REGW-1:0]  id_rt,
    input  logic [REGW-1:0]  id_rd,
    input  logic [XLEN-1:0]  id_rdata1,
    input  logic [XLEN-1:0]  id_rdata2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_alu_src,
    input  logic [CTRLW-1:0] id_alu_ctrl,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             flush,
    input  logic [REGW-1:0]  mem_rd,
    input  logic [REGW-1:0]  wb_rd,
    input  logic             mem_reg_write,
    input  logic             wb_reg_write,
    input  logic [XLEN-1:0]  mem_result,
    input  logic [XLEN-1:0]  wb_result,
    output logic             stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  A,
    output logic [XLEN-1:0]  B,
    output logic [CTRLW-1:0] ALUControl,
    output logic [REGW-1:0]  ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [XLEN-1:0]  ex_store_data
);

    logic [REGW-1:0]  ex_rs;
    logic [REGW-1:0]  ex_rt;
    logic [XLEN-1:0]  ex_rdata1;
    logic [XLEN-1:0]  ex_rdata2;
    logic [XLEN-1:0]  ex_imm;
    logic             ex_alu_src;
    logic             hazard;
    logic [XLEN-1:0]  fwd_rs;
    logic [XLEN-1:0]  fwd_rt;

`ifdef ID_EX_FORWARD_EN
    logic mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;

    assign mem_hit_rs = mem_reg_write && (mem_rd == ex_rs) && (ex_rs != '0);
    assign mem_hit_rt = mem_reg_write && (mem_rd == ex_rt) && (ex_rt != '0);
    assign wb_hit_rs  = wb_reg_write  && (wb_rd  == ex_rs) && (ex_rs != '0);
    assign wb_hit_rt  = wb_reg_write  && (wb_rd  == ex_rt) && (ex_rt != '0);

    // MEM holds the younger result, so it wins over WB.
    assign fwd_rs = mem_hit_rs ? mem_result : (wb_hit_rs ? wb_result : ex_rdata1);
    assign fwd_rt = mem_hit_rt ? mem_result : (wb_hit_rt ? wb_result : ex_rdata2);

    assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                    ((id_rs == ex_rd) || (id_rt == ex_rd));
`else
    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic unused_nofwd;

    assign fwd_rs = ex_rdata1;
    assign fwd_rt = ex_rdata2;

    assign ex_hit_rs  = ex_valid && ex_reg_write && (id_rs == ex_rd);
    assign ex_hit_rt  = ex_valid && ex_reg_write && (id_rt == ex_rd);
    assign mem_hit_rs = mem_reg_write && (id_rs == mem_rd);
    assign mem_hit_rt = mem_reg_write && (id_rt == mem_rd);

    // WB hazards need no stall: the register file writes before it is read.
    assign hazard = id_valid &&
                    (((id_rs != '0) && (ex_hit_rs || mem_hit_rs)) ||
                     ((id_rt != '0) && (ex_hit_rt || mem_hit_rt)));

    assign unused_nofwd = ^{wb_rd, wb_reg_write, wb_result, mem_result, ex_rs, ex_rt};
`endif

    // Reset empties EX, so a stall must not outlive the reset edge.
    assign stall = hazard && !reset;

    always_ff @(posedge clk) begin
        if (reset || flush || stall) begin
            ex_valid     <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_rdata1    <= '0;
            ex_rdata2    <= '0;
            ex_imm       <= '0;
            ex_alu_src   <= 1'b0;
            ALUControl   <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_rd        <= id_rd;
            ex_rdata1    <= id_rdata1;
            ex_rdata2    <= id_rdata2;
            ex_imm       <= id_imm;
            ex_alu_src   <= id_alu_src;
            ALUControl   <= id_alu_ctrl;
            ex_reg_write <= id_valid && id_reg_write;
            ex_mem_read  <= id_valid && id_mem_read;
            ex_mem_write <= id_valid && id_mem_write;
        end
    end

    assign A             = fwd_rs;
    assign B             = ex_alu_src ? ex_imm : fwd_rt;
    assign ex_store_data = fwd_rt;

endmodule
